// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Any nibble above 9 saturates to 9 so q never holds an illegal digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit of the down counter; load wins over decrement, 0 wraps to 9.
module bcd_digit_dn
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       dec_in,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 4'd0;
    end else if (ld) begin
      q_reg <= d;
    end else if (dec_in) begin
      q_reg <= (q_reg == 4'd0) ? BCD_MAX : q_reg - 4'd1;
    end
  end

  assign q          = q_reg;
  assign borrow_out = dec_in & (q_reg == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: FSM, preset register and pulse outputs
// around a ripple-borrow chain of bcd_digit_dn instances.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   q,
  output logic                  running,
  output logic                  done,
  output logic                  tc,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  tmr_state_t    state_reg, state_next;
  logic [W-1:0]  preset_reg, preset_next;
  logic          tc_reg, tc_next;
  logic          err_reg, err_next;

  logic [W-1:0]  d_clamped;
  logic [DIGITS-1:0] digit_bad;
  logic [W-1:0]  load_val;
  logic          load_q;
  logic          dec;
  logic [DIGITS:0] dec_chain;
  logic          borrow_unused;

  logic          q_zero, q_one, preset_zero;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign d_clamped[gi*4 +: 4] = bcd_clamp(d[gi*4 +: 4]);
      assign digit_bad[gi]        = (d[gi*4 +: 4] > BCD_MAX);

      bcd_digit_dn u_digit (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (load_q),
        .d          (load_val[gi*4 +: 4]),
        .dec_in     (dec_chain[gi]),
        .q          (q[gi*4 +: 4]),
        .borrow_out (dec_chain[gi+1])
      );
    end
  endgenerate

  assign dec_chain[0] = dec;
  // A borrow out of the top digit would mean underflow, which RUN rules out.
  assign borrow_unused = dec_chain[DIGITS];

  assign q_zero      = (q == '0);
  assign q_one       = (q == W'(1));
  assign preset_zero = (preset_reg == '0);

  // Commands are a strict priority chain: once ld, pause or start is seen,
  // the en tick of that cycle is discarded.
  always_comb begin
    state_next  = state_reg;
    preset_next = preset_reg;
    tc_next     = 1'b0;
    err_next    = 1'b0;
    load_q      = 1'b0;
    load_val    = preset_reg;
    dec         = 1'b0;

    if (ld) begin
      load_q      = 1'b1;
      load_val    = d_clamped;
      preset_next = d_clamped;
      err_next    = |digit_bad;
      state_next  = IDLE;
    end else if (pause) begin
      if (state_reg == RUN) state_next = IDLE;
    end else if (start) begin
      case (state_reg)
        IDLE: state_next = q_zero ? DONE : RUN;
        DONE: begin
          load_q     = 1'b1;
          state_next = preset_zero ? DONE : RUN;
        end
        default: ;
      endcase
    end else if (en && state_reg == RUN) begin
      if (q_one) begin
        tc_next = 1'b1;
        if (AUTO_RELOAD != 0) begin
          load_q     = 1'b1;
          state_next = preset_zero ? DONE : RUN;
        end else begin
          dec        = 1'b1;
          state_next = DONE;
        end
      end else begin
        dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      preset_reg <= '0;
      tc_reg     <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      preset_reg <= preset_next;
      tc_reg     <= tc_next;
      err_reg    <= err_next;
    end
  end

  assign running = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign tc      = tc_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: one instance per AUTO_RELOAD setting, both checked
// every cycle against an integer-valued reference model.
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ld = 1'b0, start = 1'b0, pause = 1'b0, en = 1'b0;
  logic [W-1:0] d = '0;

  logic [W-1:0] q0, q1;
  logic         run0, run1, done0, done1, tc0, tc1, err0, err1;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ld(ld), .d(d), .start(start), .pause(pause),
    .en(en), .q(q0), .running(run0), .done(done0), .tc(tc0), .err(err0)
  );

  bcd_down_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ld(ld), .d(d), .start(start), .pause(pause),
    .en(en), .q(q1), .running(run1), .done(done1), .tc(tc1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: count held as a plain decimal integer.
  int m_val[2];
  int m_pre[2];
  int m_st[2];
  bit m_tc[2];
  bit m_err[2];

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] x);
    int v, p, n;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(x[i*4 +: 4]);
      if (n > 9) n = 9;
      v += n * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic bit any_bad(input logic [W-1:0] x);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (x[i*4 +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_pre[k] = 0; m_st[k] = S_IDLE; m_tc[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit ar);
    m_tc[k]  = 1'b0;
    m_err[k] = 1'b0;
    if (ld) begin
      m_val[k] = clamp_val(d);
      m_pre[k] = m_val[k];
      m_err[k] = any_bad(d);
      m_st[k]  = S_IDLE;
    end else if (pause) begin
      if (m_st[k] == S_RUN) m_st[k] = S_IDLE;
    end else if (start) begin
      if (m_st[k] == S_IDLE) begin
        m_st[k] = (m_val[k] == 0) ? S_DONE : S_RUN;
      end else if (m_st[k] == S_DONE) begin
        m_val[k] = m_pre[k];
        m_st[k]  = (m_pre[k] == 0) ? S_DONE : S_RUN;
      end
    end else if (en && m_st[k] == S_RUN) begin
      m_val[k] = m_val[k] - 1;
      if (m_val[k] == 0) begin
        m_tc[k] = 1'b1;
        if (ar) begin
          m_val[k] = m_pre[k];
          m_st[k]  = (m_pre[k] == 0) ? S_DONE : S_RUN;
        end else begin
          m_st[k] = S_DONE;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("q0",    32'(q0),    32'(to_bcd(m_val[0])));
    check("run0",  32'(run0),  32'(m_st[0] == S_RUN));
    check("done0", 32'(done0), 32'(m_st[0] == S_DONE));
    check("tc0",   32'(tc0),   32'(m_tc[0]));
    check("err0",  32'(err0),  32'(m_err[0]));
    check("q1",    32'(q1),    32'(to_bcd(m_val[1])));
    check("run1",  32'(run1),  32'(m_st[1] == S_RUN));
    check("done1", 32'(done1), 32'(m_st[1] == S_DONE));
    check("tc1",   32'(tc1),   32'(m_tc[1]));
    check("err1",  32'(err1),  32'(m_err[1]));
  endtask

  // Called just after a falling edge; drives one cycle and checks after it.
  task automatic cycle(input bit l, input logic [W-1:0] dv, input bit s, input bit p, input bit e);
    ld = l; d = dv; start = s; pause = p; en = e;
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(negedge clk);
    cyc++;
    $display("cyc=%0d ld=%0b d=%04h st=%0b pa=%0b en=%0b | q0=%04h r%0b d%0b tc%0b e%0b | q1=%04h r%0b d%0b tc%0b e%0b",
             cyc, l, dv, s, p, e, q0, run0, done0, tc0, err0, q1, run1, done1, tc1, err1);
    compare_all();
    ld = 1'b0; start = 1'b0; pause = 1'b0; en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seq_exp[6] = '{2, 1, 3, 2, 1, 3};
  bit r_ld, r_st, r_pa, r_en;
  logic [W-1:0] r_d;

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-count, then clamped load.
    cycle(1, 16'h0045, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1);
    check("pre_reset_q", 32'(q0), 32'h0042);
    do_reset();
    check("reset_q", 32'(q0), 32'h0000);
    cycle(1, 16'h00A7, 0, 0, 0);
    check("clamp_q", 32'(q0), 32'h0097);
    check("clamp_err", 32'(err0), 32'h1);
    cycle(0, '0, 0, 0, 0);
    check("err_pulse", 32'(err0), 32'h0);

    // Borrow across digits.
    cycle(1, 16'h0100, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1);
    check("borrow_q", 32'(q0), 32'h0097);

    // Terminal count with and without reload.
    cycle(1, 16'h0002, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 1);
    check("term_tc", 32'(tc0), 32'h1);
    check("term_done", 32'(done0), 32'h1);
    cycle(0, '0, 0, 0, 1);
    check("term_hold", 32'(q0), 32'h0000);
    check("term_tc_off", 32'(tc0), 32'h0);

    cycle(1, 16'h0003, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, '0, 0, 0, 1);
      check("reload_seq", 32'(q1), 32'(seq_exp[i]));
      check("reload_run", 32'(run1), 32'h1);
    end

    // Pause, resume and priority.
    cycle(1, 16'h0051, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 1, 1);
    check("pause_q", 32'(q0), 32'h0050);
    check("pause_run", 32'(run0), 32'h0);
    cycle(0, '0, 1, 0, 1);
    check("resume_q", 32'(q0), 32'h0050);
    cycle(0, '0, 0, 0, 1);
    check("resume_dec", 32'(q0), 32'h0049);
    cycle(1, 16'h0123, 1, 0, 1);
    check("ld_prio_q", 32'(q0), 32'h0123);
    check("ld_prio_run", 32'(run0), 32'h0);

    // Zero start, then restart from DONE.
    cycle(1, 16'h0000, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    check("zero_done", 32'(done0), 32'h1);
    check("zero_tc", 32'(tc0), 32'h0);
    cycle(1, 16'h0005, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 0, 1);
    check("restart_q", 32'(q0), 32'h0004);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r_ld = ($urandom_range(0, 24) == 0);
      r_pa = ($urandom_range(0, 24) == 0);
      r_st = ($urandom_range(0, 9) == 0);
      r_en = ($urandom_range(0, 1) == 1);
      r_d  = ($urandom_range(0, 2) == 0) ? W'($urandom) : to_bcd($urandom_range(0, 12));
      cycle(r_ld, r_d, r_st, r_pa, r_en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
